// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: byte-serial RAM controller arbitrating instruction fetch against data loads/stores.
// Latency: reads take N+1 busy cycles then one ack cycle; stores take N cycles (plus IO stalls) then ack.
// Backpressure: rdy=0 freezes all state; io_buffer_full stalls IO-region stores. Optional if_flush under MEMCTRL_IF_FLUSH_EN.
module mem_burst_ctrl #(
    parameter int         ADDR_W        = 32,
    parameter int         IF_LINE_BYTES = 4,
    parameter int         STARVE_LIMIT  = 4,
    parameter logic [1:0] IO_SEL_HI     = 2'b11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       io_buffer_full,
    input  logic [7:0]                 mem_din,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_a,
    output logic [7:0]                 mem_dout,
    input  logic                       if_req,
    input  logic [ADDR_W-1:0]          if_addr,
`ifdef MEMCTRL_IF_FLUSH_EN
    input  logic                       if_flush,
`endif
    output logic                       if_ack,
    output logic [8*IF_LINE_BYTES-1:0] if_data,
    input  logic                       dc_req,
    input  logic                       dc_we,
    input  logic [1:0]                 dc_len,
    input  logic [ADDR_W-1:0]          dc_addr,
    input  logic [31:0]                dc_wdata,
    output logic                       dc_ack,
    output logic [31:0]                dc_rdata
);
    localparam int CW = $clog2(IF_LINE_BYTES) + 1;
    localparam int IW = CW - 1;

    typedef enum logic [2:0] {IDLE, IF_RD, DC_RD, DC_WR, ACK} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     len_n;
    logic [ADDR_W-1:0] base;
    logic [31:0]       wdata;
    logic              is_dc;
    logic [3:0]        starve;
    logic [7:0]        line [IF_LINE_BYTES];

    logic              flush;
    logic              gnt_dc;
    logic              gnt_if;
    logic              cnt_inc;
    logic              cap;
    logic              io_stall;
    logic              rd_state;
    logic [CW-1:0]     rd_idx;
    logic [IW-1:0]     cap_idx;
    logic [CW-1:0]     dc_n;

`ifdef MEMCTRL_IF_FLUSH_EN
    assign flush = if_flush;
`else
    assign flush = 1'b0;
`endif

    assign io_stall = (base[17:16] == IO_SEL_HI) && io_buffer_full;
    assign rd_state = (state == IF_RD) || (state == DC_RD);
    // On the final read cycle (cnt == N) the address holds at the last byte.
    assign rd_idx   = (cnt == len_n) ? cnt - CW'(1) : cnt;
    assign cap_idx  = IW'(cnt - CW'(1));

    always_comb begin
        case (dc_len)
            2'b00:   dc_n = CW'(1);
            2'b01:   dc_n = CW'(2);
            default: dc_n = CW'(4);
        endcase
    end

    always_comb begin
        state_nxt = state;
        gnt_dc    = 1'b0;
        gnt_if    = 1'b0;
        cnt_inc   = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (dc_req && ((starve < 4'(STARVE_LIMIT)) || !if_req)) begin
                    gnt_dc    = 1'b1;
                    state_nxt = dc_we ? DC_WR : DC_RD;
                end else if (if_req && !flush) begin
                    gnt_if    = 1'b1;
                    state_nxt = IF_RD;
                end
            end
            IF_RD, DC_RD: begin
                if ((state == IF_RD) && flush) begin
                    state_nxt = IDLE;
                end else begin
                    cap = (cnt != '0);
                    if (cnt == len_n) begin
                        state_nxt = ACK;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            DC_WR: begin
                if (!io_stall) begin
                    if (cnt == len_n - CW'(1)) begin
                        state_nxt = ACK;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            len_n  <= '0;
            base   <= '0;
            wdata  <= '0;
            is_dc  <= 1'b0;
            starve <= '0;
            for (int k = 0; k < IF_LINE_BYTES; k++) begin
                line[k] <= '0;
            end
        end else if (rdy) begin
            if (gnt_dc || gnt_if) begin
                cnt   <= '0;
                base  <= gnt_dc ? dc_addr : if_addr;
                len_n <= gnt_dc ? dc_n : CW'(IF_LINE_BYTES);
                wdata <= gnt_dc ? dc_wdata : '0;
                is_dc <= gnt_dc;
                // Clearing the buffer makes unread bytes of a short load read as zero.
                for (int k = 0; k < IF_LINE_BYTES; k++) begin
                    line[k] <= '0;
                end
                starve <= (gnt_dc && if_req) ? starve + 4'd1 : 4'd0;
            end else begin
                if (cnt_inc) begin
                    cnt <= cnt + CW'(1);
                end
                if (cap) begin
                    line[cap_idx] <= mem_din;
                end
            end
        end
    end

    always_comb begin
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        if (rd_state) begin
            mem_a = base + ADDR_W'(rd_idx);
        end else if (state == DC_WR) begin
            mem_a    = base + ADDR_W'(cnt);
            mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
            mem_wr   = rdy && !io_stall;
        end
    end

    assign if_ack   = (state == ACK) && !is_dc;
    assign dc_ack   = (state == ACK) && is_dc;
    assign dc_rdata = {line[3], line[2], line[1], line[0]};

    for (genvar k = 0; k < IF_LINE_BYTES; k++) begin : g_if_data
        assign if_data[8*k +: 8] = line[k];
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: byte RAM model, shadow memory reference, vector table and directed corner cases.
`timescale 1ns/1ps
module tb_mem_burst_ctrl;
    localparam int AW = 32;
    localparam int LB = 4;
    localparam int SL = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            rdy = 1'b1;
    logic            io_buffer_full = 1'b0;
    logic [7:0]      mem_din = 8'h00;
    logic            mem_wr;
    logic [AW-1:0]   mem_a;
    logic [7:0]      mem_dout;
    logic            if_req = 1'b0;
    logic [AW-1:0]   if_addr = '0;
    logic            if_ack;
    logic [8*LB-1:0] if_data;
    logic            dc_req = 1'b0;
    logic            dc_we = 1'b0;
    logic [1:0]      dc_len = 2'b00;
    logic [AW-1:0]   dc_addr = '0;
    logic [31:0]     dc_wdata = '0;
    logic            dc_ack;
    logic [31:0]     dc_rdata;
`ifdef MEMCTRL_IF_FLUSH_EN
    logic            if_flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    bit rnd_mode = 1'b0;

    logic [7:0]  ram    [logic [31:0]];
    logic [7:0]  shadow [logic [31:0]];
    logic [39:0] wlog [$];
    logic        s_wr;
    logic        s_rdy;
    logic [31:0] s_a;
    logic [7:0]  s_d;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.ADDR_W(AW), .IF_LINE_BYTES(LB), .STARVE_LIMIT(SL), .IO_SEL_HI(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout),
        .if_req(if_req), .if_addr(if_addr),
`ifdef MEMCTRL_IF_FLUSH_EN
        .if_flush(if_flush),
`endif
        .if_ack(if_ack), .if_data(if_data),
        .dc_req(dc_req), .dc_we(dc_we), .dc_len(dc_len), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_ack(dc_ack), .dc_rdata(dc_rdata)
    );

    // Power-up RAM contents: a fixed function of the address.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_byte(a);
    endfunction

    function automatic int nlen(input logic [1:0] l);
        return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
    endfunction

    always @(negedge clk) begin
        s_wr  = mem_wr;
        s_a   = mem_a;
        s_d   = mem_dout;
        s_rdy = rdy;
    end

    // Synchronous byte RAM sharing the global enable: read data one enabled cycle after its address.
    always @(posedge clk) begin
        if (s_wr) begin
            ram[s_a] = s_d;
            wlog.push_back({s_a, s_d});
        end
        if (s_rdy) mem_din <= ram_rd(s_a);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            rdy            = ($urandom_range(0, 3) != 0);
            io_buffer_full = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic dc_op(input logic we, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output bit got);
        got = 1'b0;
        rd  = '0;
        dc_we = we; dc_len = len; dc_addr = addr; dc_wdata = wd; dc_req = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (dc_ack) begin
                rd  = dc_rdata;
                got = 1'b1;
                break;
            end
        end
        dc_req = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!dc_ack) break;
            tick();
        end
    endtask

    task automatic chk_writes(input string nm, input int w0, input logic [31:0] addr,
                              input logic [31:0] wd, input int n);
        logic [31:0] a;
        chk({nm, " nwr"}, 64'(wlog.size() - w0), 64'(n));
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            if (w0 + i < wlog.size()) chk({nm, " wr"}, 64'(wlog[w0 + i]), 64'({a, wd[8*i +: 8]}));
            shadow[a] = wd[8*i +: 8];
        end
    endtask

    task automatic check_dc(input string nm, input logic we, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input bit use_exp, input logic [31:0] exp);
        int          n;
        int          w0;
        logic [31:0] mdl;
        logic [31:0] rd;
        bit          got;
        n   = nlen(len);
        w0  = wlog.size();
        mdl = '0;
        for (int i = 0; i < n; i++) mdl[8*i +: 8] = sh_rd(addr + 32'(i));
        dc_op(we, len, addr, wd, rd, got);
        chk({nm, " ack"}, 64'(got), 64'(1));
        if (we) begin
            chk_writes(nm, w0, addr, wd, n);
        end else begin
            chk({nm, " rdata"}, 64'(rd), 64'(mdl));
            if (use_exp) chk({nm, " tbl"}, 64'(rd), 64'(exp));
            chk({nm, " nowr"}, 64'(wlog.size() - w0), 64'(0));
        end
    endtask

    task automatic check_if(input string nm, input logic [31:0] addr);
        logic [8*LB-1:0] exp;
        logic [8*LB-1:0] got_d;
        bit              got;
        int              w0;
        w0 = wlog.size();
        got = 1'b0;
        got_d = '0;
        for (int k = 0; k < LB; k++) exp[8*k +: 8] = sh_rd(addr + 32'(k));
        if_addr = addr;
        if_req  = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (if_ack) begin
                got_d = if_data;
                got   = 1'b1;
                break;
            end
        end
        if_req = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!if_ack) break;
            tick();
        end
        chk({nm, " ack"}, 64'(got), 64'(1));
        chk({nm, " data"}, 64'(got_d), 64'(exp));
        chk({nm, " nowr"}, 64'(wlog.size() - w0), 64'(0));
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl [13];
        logic [31:0] a_seq [6];
        logic [31:0] got_a [6];
        logic        got_k [6];
        logic [31:0] line_at_ack;
        int          order [$];
        int          exp_order [6];
        int          w0;
        int          nack;
        logic        wr_pat [7];
        logic        ack_pat [7];

        tbl[0]  = '{1'b1, 2'b01, 32'h0000_2001, 32'hAABB_CCDD, 32'h0};
        tbl[1]  = '{1'b0, 2'b01, 32'h0000_2001, 32'h0,         32'h0000_CCDD};
        tbl[2]  = '{1'b0, 2'b00, 32'h0000_2001, 32'h0,         32'h0000_00DD};
        tbl[3]  = '{1'b1, 2'b00, 32'h0000_0040, 32'h1234_56F7, 32'h0};
        tbl[4]  = '{1'b0, 2'b00, 32'h0000_0040, 32'h0,         32'h0000_00F7};
        tbl[5]  = '{1'b1, 2'b10, 32'h0000_03FE, 32'h1122_3344, 32'h0};
        tbl[6]  = '{1'b0, 2'b01, 32'h0000_03FF, 32'h0,         32'h0000_2233};
        tbl[7]  = '{1'b0, 2'b11, 32'h0000_03FE, 32'h0,         32'h1122_3344};
        tbl[8]  = '{1'b1, 2'b10, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0};
        tbl[9]  = '{1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         32'h0000_BEEF};
        tbl[10] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,         32'h0000_00BE};
        tbl[11] = '{1'b1, 2'b11, 32'h0000_0600, 32'h0102_0304, 32'h0};
        tbl[12] = '{1'b0, 2'b10, 32'h0000_0600, 32'h0,         32'h0102_0304};

        #1 rst_n = 1'b0;
        #3;
        chk("rst mem_wr", 64'(mem_wr), 64'(0));
        chk("rst mem_a", 64'(mem_a), 64'(0));
        chk("rst mem_dout", 64'(mem_dout), 64'(0));
        chk("rst acks", 64'({if_ack, dc_ack}), 64'(0));
        chk("rst data", 64'({if_data, dc_rdata}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Put the instruction word 0x00100513 at 0x100 for the fetch sequence.
        check_dc("st100", 1'b1, 2'b10, 32'h100, 32'h0010_0513, 1'b0, 32'h0);

        a_seq = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h103, 32'h0};
        if_addr = 32'h100;
        if_req  = 1'b1;
        line_at_ack = '0;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk);
            #2;
            got_a[s] = mem_a;
            got_k[s] = if_ack;
            if (if_ack) line_at_ack = if_data;
        end
        if_req = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("fetch mem_a c%0d", s), 64'(got_a[s]), 64'(a_seq[s]));
            chk($sformatf("fetch early ack c%0d", s), 64'(got_k[s]), 64'(0));
        end
        chk("fetch ack c5", 64'(got_k[5]), 64'(1));
        chk("fetch if_data", 64'(line_at_ack), 64'(32'h0010_0513));
        tick();

        for (int i = 0; i < 13; i++)
            check_dc($sformatf("tbl%0d", i), tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wd, 1'b1, tbl[i].exp);

        // IO store with io_buffer_full raised for three cycles starting at the second byte.
        w0 = wlog.size();
        dc_we = 1'b1; dc_len = 2'b10; dc_addr = 32'h0003_0000; dc_wdata = 32'h4433_2211; dc_req = 1'b1;
        nack = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #2;
            if (mem_wr) break;
        end
        chk("io byte0 addr", 64'(mem_a), 64'(32'h0003_0000));
        chk("io byte0 data", 64'(mem_dout), 64'(8'h11));
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1 io_buffer_full = (i < 3);
            #1;
            wr_pat[i]  = mem_wr;
            ack_pat[i] = dc_ack;
        end
        dc_req = 1'b0;
        io_buffer_full = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("io mem_wr c%0d", i), 64'(wr_pat[i]), 64'((i >= 3 && i < 6) ? 1 : 0));
            chk($sformatf("io ack c%0d", i), 64'(ack_pat[i]), 64'((i == 6) ? 1 : 0));
        end
        chk_writes("io", w0, 32'h0003_0000, 32'h4433_2211, 4);
        tick();

        // Both clients held: data wins until the starvation limit, then fetch gets a turn.
        exp_order = '{1, 1, 2, 1, 1, 2};
        dc_we = 1'b0; dc_len = 2'b00; dc_addr = 32'h40; dc_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (dc_ack) order.push_back(1);
            if (if_ack) order.push_back(2);
            if (order.size() >= 6) break;
        end
        dc_req = 1'b0;
        if_req = 1'b0;
        tick();
        chk("arb count", 64'(order.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            if (i < order.size()) chk($sformatf("arb grant%0d", i), 64'(order[i]), 64'(exp_order[i]));

        // Reset in the middle of a fetch.
        if_addr = 32'h200;
        if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst mem_a", 64'(mem_a), 64'(0));
        chk("midrst strobes", 64'({mem_wr, if_ack, dc_ack}), 64'(0));
        chk("midrst data", 64'({if_data, dc_rdata, mem_dout}), 64'(0));
        if_req = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        nack = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (if_ack || dc_ack) nack++;
        end
        chk("midrst no ack", 64'(nack), 64'(0));
        check_if("postrst fetch", 32'h100);

        rnd_mode = 1'b1;
        for (int t = 0; t < 100; t++) begin
            int          sel;
            logic [31:0] a;
            logic [1:0]  l;
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
                    1:       a = 32'h500 + 32'($urandom_range(0, 15)) * 4;
                    default: a = 32'hFFFF_FFFC;
                endcase
                check_if($sformatf("rnd%0d fetch", t), a);
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = 32'h500 + 32'($urandom_range(0, 63));
                    1:       a = 32'h0003_0000 + 32'($urandom_range(0, 15));
                    default: a = 32'hFFFF_FFFE + 32'($urandom_range(0, 3));
                endcase
                l = 2'($urandom_range(0, 3));
                check_dc($sformatf("rnd%0d dc", t), 1'($urandom_range(0, 1)), l, a, $urandom, 1'b0, 32'h0);
            end
        end
        rnd_mode = 1'b0;
        rdy = 1'b1;
        io_buffer_full = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
